// File: rtl/bus_transfer_sequencer_if.sv
// Request/status channel between a transfer requester and bus_transfer_sequencer.
// The requester holds the master modport; the sequencer holds the slave modport.
interface bus_transfer_sequencer_if #(
    parameter int SelWidth = 3,
    parameter int BitWidth = 8
);
    logic                ReqValid;
    logic                ReqReady;
    logic                ReqImm;
    logic [SelWidth-1:0] SrcSel;
    logic [SelWidth-1:0] DstSel;
    logic [BitWidth-1:0] ImmData;
    logic                Busy;
    logic                Done;
    logic                Error;
    logic [BitWidth-1:0] Data;

    modport master (
        output ReqValid, ReqImm, SrcSel, DstSel, ImmData,
        input  ReqReady, Busy, Done, Error, Data
    );

    modport slave (
        input  ReqValid, ReqImm, SrcSel, DstSel, ImmData,
        output ReqReady, Busy, Done, Error, Data
    );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Sequences one register-to-register or immediate-to-register move at a time
// over a shared tri-state bus by driving the register bank's active-low OE/EN strobes.
module bus_transfer_sequencer #(
    parameter int NumRegs  = 8,
    parameter int SelWidth = 3,
    parameter int BitWidth = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    bus_transfer_sequencer_if.slave req,
    inout  tri   [BitWidth-1:0]  Bus,
    output logic [NumRegs-1:0]   OE_N,
    output logic [NumRegs-1:0]   EN_N
);

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, TURN} state_t;

    state_t              state_q, state_d;
    logic                ready, accept, legal;
    logic                driving, bus_oe;
    logic [SelWidth-1:0] src_p0, dst_p0;
    logic                immsel_p0;
    logic [BitWidth-1:0] imm_p0;
    logic                err_p0;
    logic [BitWidth-1:0] data_p1;

    assign accept = req.ReqValid & ready;

    always_comb begin
        legal = 1'b1;
        if (int'(req.DstSel) >= NumRegs)
            legal = 1'b0;
        if (!req.ReqImm && ((int'(req.SrcSel) >= NumRegs) || (req.SrcSel == req.DstSel)))
            legal = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Illegal requests skip the bus phases entirely and just report in TURN
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = legal ? DRIVE : TURN;
            DRIVE:   state_d = LOAD;
            LOAD:    state_d = TURN;
            TURN:    state_d = accept ? (legal ? DRIVE : TURN) : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: request captured at acceptance
    always_ff @(posedge Clk) begin
        if (accept) begin
            src_p0    <= req.SrcSel;
            dst_p0    <= req.DstSel;
            immsel_p0 <= req.ReqImm;
            imm_p0    <= req.ImmData;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset)
            err_p0 <= 1'b0;
        else if (accept)
            err_p0 <= !legal;
    end

    // Stage p1: bus value sampled on the edge that ends LOAD
    always_ff @(posedge Clk) begin
        if (!Reset)
            data_p1 <= '0;
        else if (state_q == LOAD)
            data_p1 <= Bus;
    end

    always_comb begin
        ready   = (state_q == IDLE) || (state_q == TURN);
        driving = (state_q == DRIVE) || (state_q == LOAD);
        bus_oe  = driving && immsel_p0;
        OE_N    = '1;
        EN_N    = '1;
        for (int i = 0; i < NumRegs; i++) begin
            if (driving && !immsel_p0 && (src_p0 == SelWidth'(i)))
                OE_N[i] = 1'b0;
            if ((state_q == LOAD) && (dst_p0 == SelWidth'(i)))
                EN_N[i] = 1'b0;
        end
    end

    assign Bus          = bus_oe ? imm_p0 : {BitWidth{1'bz}};
    assign req.ReqReady = ready;
    assign req.Busy     = (state_q != IDLE);
    assign req.Done     = (state_q == TURN);
    assign req.Error    = (state_q == TURN) && err_p0;
    assign req.Data     = data_p1;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Directed and random bench for bus_transfer_sequencer with a behavioural
// register bank on the bus, a protocol monitor and a completion scoreboard.
module tb_bus_transfer_sequencer;
    localparam int NR = 8;
    localparam int SW = 4;
    localparam int BW = 8;

    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    bus_transfer_sequencer_if #(.SelWidth(SW), .BitWidth(BW)) req_if ();
    wire  [BW-1:0] Bus;
    logic [NR-1:0] OE_N, EN_N;

    bus_transfer_sequencer #(.NumRegs(NR), .SelWidth(SW), .BitWidth(BW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .req   (req_if),
        .Bus   (Bus),
        .OE_N  (OE_N),
        .EN_N  (EN_N)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural register bank: drives Bus when its OE_N is low, loads on EN_N low
    logic [BW-1:0] regs [NR] = '{default: '0};
    logic          oe_any;
    logic [2:0]    oe_idx;
    always_comb begin
        oe_any = 1'b0;
        oe_idx = 3'd0;
        for (int i = 0; i < NR; i++)
            if (!OE_N[i]) begin
                oe_any = 1'b1;
                oe_idx = 3'(i);
            end
    end
    assign Bus = oe_any ? regs[oe_idx] : {BW{1'bz}};
    always @(posedge Clk)
        for (int i = 0; i < NR; i++)
            if (!EN_N[i]) regs[i] <= Bus;

    typedef struct {
        bit          err;
        logic [7:0]  data;
        int          dst;
        int          due;
    } exp_t;

    exp_t          sb [$];
    exp_t          mon_e;
    logic [BW-1:0] ref_regs [NR] = '{default: '0};
    logic [BW-1:0] last_good = '0;
    logic [63:0]   bank_act, bank_exp;
    bit            mon_illegal;
    int            mon_src, mon_dst;

    always @(negedge Clk) begin
        if (!Reset) begin
            sb.delete();
            last_good = '0;
        end else begin
            check1("oe_at_most_one", $countones(~OE_N) <= 1, 1'b1);
            check1("en_at_most_one", $countones(~EN_N) <= 1, 1'b1);
            check1("bus_vs_oe_contention", dut.bus_oe && (~&OE_N), 1'b0);
            check1("error_implies_done", req_if.Error && !req_if.Done, 1'b0);
            if (~&EN_N)
                check1("load_has_driver", (~&OE_N) || dut.bus_oe, 1'b1);
            if (req_if.Done) begin
                check8("turn_oe_released", OE_N, 8'hFF);
                check8("turn_en_released", EN_N, 8'hFF);
                check1("turn_bus_released", dut.bus_oe, 1'b0);
                if (sb.size() == 0) begin
                    checki("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    checki("done_cycle", cyc, mon_e.due);
                    check1("error_flag", req_if.Error, mon_e.err);
                    if (!mon_e.err) begin
                        check8("data_out", req_if.Data, mon_e.data);
                        check8("dst_reg", regs[mon_e.dst], mon_e.data);
                        last_good = mon_e.data;
                    end else begin
                        check8("data_kept", req_if.Data, last_good);
                    end
                    for (int i = 0; i < NR; i++) begin
                        bank_act[i*8 +: 8] = regs[i];
                        bank_exp[i*8 +: 8] = ref_regs[i];
                    end
                    checkw("reg_bank", bank_act, bank_exp);
                end
            end
            // Expectations are fixed from the inputs present at the accepting edge
            if (req_if.ReqValid && req_if.ReqReady) begin
                mon_src     = int'(req_if.SrcSel);
                mon_dst     = int'(req_if.DstSel);
                mon_illegal = (mon_dst >= NR) ||
                              (!req_if.ReqImm && ((mon_src >= NR) || (mon_src == mon_dst)));
                mon_e.err  = mon_illegal;
                mon_e.dst  = mon_dst;
                mon_e.due  = cyc + (mon_illegal ? 1 : 3);
                mon_e.data = '0;
                if (!mon_illegal) begin
                    mon_e.data = req_if.ReqImm ? req_if.ImmData : ref_regs[mon_src];
                    ref_regs[mon_dst] = mon_e.data;
                end
                sb.push_back(mon_e);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    task automatic send(input bit imm, input int src, input int dst, input logic [7:0] d, input bit keep);
        int n;
        n = 0;
        req_if.ReqValid = 1'b1;
        req_if.ReqImm   = imm;
        req_if.SrcSel   = SW'(src);
        req_if.DstSel   = SW'(dst);
        req_if.ImmData  = d;
        while (!req_if.ReqReady && n < 10) begin
            step();
            n++;
        end
        check1("accept_wait_bounded", n < 10, 1'b1);
        step();
        if (!keep) begin
            req_if.ReqValid = 1'b0;
            req_if.ReqImm   = 1'($urandom);
            req_if.SrcSel   = SW'($urandom);
            req_if.DstSel   = SW'($urandom);
            req_if.ImmData  = BW'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (req_if.Busy && n < 20) begin
            step();
            n++;
        end
        check1("idle_wait_bounded", n < 20, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pre [8];
        bit keep;
        pre = '{8'h0F, 8'h5A, 8'hA5, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        req_if.ReqValid = 1'b0;
        req_if.ReqImm   = 1'b0;
        req_if.SrcSel   = '0;
        req_if.DstSel   = '0;
        req_if.ImmData  = '0;

        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #2;
        check8("rst_oe", OE_N, 8'hFF);
        check8("rst_en", EN_N, 8'hFF);
        check1("rst_busy", req_if.Busy, 1'b0);
        check1("rst_done", req_if.Done, 1'b0);
        check1("rst_error", req_if.Error, 1'b0);
        check8("rst_data", req_if.Data, 8'h00);
        check1("rst_ready", req_if.ReqReady, 1'b1);
        check1("rst_bus_released", dut.bus_oe, 1'b0);
        Reset = 1'b1;

        for (int i = 0; i < NR; i++) begin
            send(1'b1, 0, i, pre[i], 1'b0);
            wait_idle();
        end

        // Register move 2 -> 5
        send(1'b0, 2, 5, 8'hEE, 1'b0);
        check8("mv_drive_oe", OE_N, 8'hFB);
        check8("mv_drive_en", EN_N, 8'hFF);
        check8("mv_drive_bus", Bus, 8'hA5);
        step();
        check8("mv_load_oe", OE_N, 8'hFB);
        check8("mv_load_en", EN_N, 8'hDF);
        step();
        check8("mv_turn_oe", OE_N, 8'hFF);
        check1("mv_turn_done", req_if.Done, 1'b1);
        check8("mv_data", req_if.Data, 8'hA5);
        check8("mv_reg5", regs[5], 8'hA5);
        wait_idle();

        // Immediate 3C -> reg0
        send(1'b1, 7, 0, 8'h3C, 1'b0);
        check8("imm_drive_bus", Bus, 8'h3C);
        check8("imm_drive_oe", OE_N, 8'hFF);
        check1("imm_drive_bus_oe", dut.bus_oe, 1'b1);
        step();
        check8("imm_load_bus", Bus, 8'h3C);
        check8("imm_load_en", EN_N, 8'hFE);
        check8("imm_load_oe", OE_N, 8'hFF);
        step();
        check1("imm_turn_bus_released", dut.bus_oe, 1'b0);
        check8("imm_reg0", regs[0], 8'h3C);
        wait_idle();

        // Back-to-back 1 -> 2 then 2 -> 3 with ReqValid held high
        send(1'b0, 1, 2, 8'h00, 1'b1);
        step();
        step();
        check1("b2b_turn_ready", req_if.ReqReady, 1'b1);
        check1("b2b_turn_valid_held", req_if.ReqValid, 1'b1);
        check8("b2b_turn_oe", OE_N, 8'hFF);
        send(1'b0, 2, 3, 8'h00, 1'b0);
        check1("b2b_second_busy", req_if.Busy, 1'b1);
        wait_idle();
        check8("b2b_reg3", regs[3], 8'h5A);
        check8("b2b_data", req_if.Data, 8'h5A);

        // Illegal requests
        send(1'b0, 4, 4, 8'h00, 1'b0);
        check1("ill_same_done", req_if.Done, 1'b1);
        check1("ill_same_error", req_if.Error, 1'b1);
        check8("ill_same_oe", OE_N, 8'hFF);
        check8("ill_same_en", EN_N, 8'hFF);
        check8("ill_same_data", req_if.Data, 8'h5A);
        wait_idle();
        send(1'b0, 1, 9, 8'h00, 1'b0);
        check1("ill_dst_done", req_if.Done, 1'b1);
        check1("ill_dst_error", req_if.Error, 1'b1);
        check8("ill_dst_oe", OE_N, 8'hFF);
        check8("ill_dst_en", EN_N, 8'hFF);
        check8("ill_dst_data", req_if.Data, 8'h5A);
        wait_idle();

        // Reset held for two edges starting in LOAD of a 3 -> 6 move
        send(1'b0, 3, 6, 8'h00, 1'b0);
        step();
        Reset = 1'b0;
        step();
        step();
        check8("abort_oe", OE_N, 8'hFF);
        check8("abort_en", EN_N, 8'hFF);
        check1("abort_busy", req_if.Busy, 1'b0);
        check8("abort_data", req_if.Data, 8'h00);
        check1("abort_ready", req_if.ReqReady, 1'b1);
        Reset = 1'b1;
        step();
        check8("abort_no_late_load", EN_N, 8'hFF);

        // Random legal and illegal traffic
        for (int k = 0; k < 40; k++) begin
            keep = 1'($urandom);
            send(1'($urandom), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
                 BW'($urandom), keep);
            if (!keep) repeat ($urandom_range(0, 2)) step();
        end
        req_if.ReqValid = 1'b0;
        wait_idle();
        step();
        step();
        checki("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
